mem_op_controller: RTL and testbench

- Memory-operation sequencer between the microprogrammed control unit and the single-port data/instruction RAM.
- Accepts an MFA request with R/W, size and address from the CU control word; drives RAM enables, byte lanes and steered data.
- Inserts a parameterised number of wait states, then returns MOC. The CU's MOC-wait microstates stall on this handshake.

---
 rtl/mem_ctrl_pkg.sv | 16 +
 rtl/mem_lane_steer.sv | 57 +++++
 rtl/mem_op_controller.sv | 121 ++++++++++++
 tb/tb_mem_op_controller.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory-operation controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/mem_lane_steer.sv
// Combinational little-endian lane steering, read extraction and alignment check.
// Optional sign extension of sub-word reads under MEMCTRL_SIGN_EXT_EN.
module mem_lane_steer
  import mem_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] ram_rdata,
`ifdef MEMCTRL_SIGN_EXT_EN
  input  logic        sign_ext,
`endif
  output logic [3:0]  ram_be,
  output logic [31:0] ram_wdata,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  always_comb begin
    ram_be     = '0;
    ram_wdata  = '0;
    rdata_ext  = '0;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        ram_be    = 4'b0001 << addr_lo;
        ram_wdata = {4{wdata[7:0]}};
        case (addr_lo)
          2'd0:    rdata_ext = {24'd0, ram_rdata[7:0]};
          2'd1:    rdata_ext = {24'd0, ram_rdata[15:8]};
          2'd2:    rdata_ext = {24'd0, ram_rdata[23:16]};
          default: rdata_ext = {24'd0, ram_rdata[31:24]};
        endcase
`ifdef MEMCTRL_SIGN_EXT_EN
        if (sign_ext) rdata_ext[31:8] = {24{rdata_ext[7]}};
`endif
      end
      SZ_HALF: begin
        ram_be     = addr_lo[1] ? 4'b1100 : 4'b0011;
        ram_wdata  = {2{wdata[15:0]}};
        rdata_ext  = addr_lo[1] ? {16'd0, ram_rdata[31:16]} : {16'd0, ram_rdata[15:0]};
        misaligned = addr_lo[0];
`ifdef MEMCTRL_SIGN_EXT_EN
        if (sign_ext) rdata_ext[31:16] = {16{rdata_ext[15]}};
`endif
      end
      default: begin
        // reserved size 11 behaves as a word access
        ram_be     = 4'b1111;
        ram_wdata  = wdata;
        rdata_ext  = ram_rdata;
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_op_controller.sv
// Memory-operation sequencer: MFA/MOC handshake, wait-state insertion, RAM lane control.
// Build option MEMCTRL_SIGN_EXT_EN adds the sign_ext input for signed sub-word loads.
module mem_op_controller
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MFA,
  input  logic              RW,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              MOC,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
`ifdef MEMCTRL_SIGN_EXT_EN
  ,input logic              sign_ext
`endif
);

  state_t                state, state_nx;
  logic [WAIT_CNT_W-1:0] cnt;
  logic                  cap_rw;
  logic [1:0]            cap_size;
  logic [ADDR_W-1:0]     cap_addr;
  logic [31:0]           cap_wdata;
  logic [1:0]            st_size;
  logic [1:0]            st_addr;
  logic [3:0]            be_raw;
  logic [31:0]           rdata_ext;
  logic                  misaligned;

  // In IDLE the steering unit looks at the live request so alignment is known at capture.
  assign st_size  = (state == IDLE) ? size      : cap_size;
  assign st_addr  = (state == IDLE) ? addr[1:0] : cap_addr[1:0];
  assign ram_addr = {cap_addr[ADDR_W-1:2], 2'b00};

`ifdef MEMCTRL_SIGN_EXT_EN
  logic cap_sext;
`endif

  mem_lane_steer u_steer (
    .size       (st_size),
    .addr_lo    (st_addr),
    .wdata      (cap_wdata),
    .ram_rdata  (ram_rdata),
`ifdef MEMCTRL_SIGN_EXT_EN
    .sign_ext   (cap_sext),
`endif
    .ram_be     (be_raw),
    .ram_wdata  (ram_wdata),
    .rdata_ext  (rdata_ext),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (MFA) state_nx = misaligned ? COMPLETE : ACCESS;
      ACCESS:   if (cnt == '0) state_nx = COMPLETE;
      COMPLETE: if (!MFA) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    ram_en = (state == ACCESS);
    ram_we = ram_en & ~cap_rw;
    ram_be = ram_en ? be_raw : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      cap_rw    <= 1'b0;
      cap_size  <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      rdata     <= '0;
      MOC       <= 1'b0;
      err       <= 1'b0;
`ifdef MEMCTRL_SIGN_EXT_EN
      cap_sext  <= 1'b0;
`endif
    end else begin
      if (state == IDLE && MFA) begin
        cnt       <= WAIT_CNT_W'(WAIT_STATES);
        cap_rw    <= RW;
        cap_size  <= size;
        cap_addr  <= addr;
        cap_wdata <= wdata;
`ifdef MEMCTRL_SIGN_EXT_EN
        cap_sext  <= sign_ext;
`endif
      end else if (state == ACCESS && cnt != '0) begin
        cnt <= cnt - WAIT_CNT_W'(1);
      end
      if (state == ACCESS && cnt == '0 && cap_rw) rdata <= rdata_ext;
      MOC <= (state_nx == COMPLETE);
      if (state == IDLE)          err <= MFA & misaligned;
      else if (state_nx == IDLE)  err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_op_controller.sv
// Directed self-checking bench for mem_op_controller (WAIT_STATES=2 and WAIT_STATES=0 instances).
module tb_mem_op_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MFA, mfa0, RW, sign_ext;
  logic [1:0]  size;
  logic [7:0]  addr;
  logic [31:0] wdata, ram_rdata;

  logic        MOC, err, busy, ram_en, ram_we;
  logic [31:0] rdata, ram_wdata;
  logic [3:0]  ram_be;
  logic [7:0]  ram_addr;

  logic        MOC0, err0, busy0, ram_en0, ram_we0;
  logic [31:0] rdata0, ram_wdata0;
  logic [3:0]  ram_be0;
  logic [7:0]  ram_addr0;

  always #5 clk = ~clk;

  mem_op_controller #(.ADDR_W(8), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset), .MFA(MFA), .RW(RW), .size(size), .addr(addr),
    .wdata(wdata), .MOC(MOC), .rdata(rdata), .err(err), .busy(busy),
    .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef MEMCTRL_SIGN_EXT_EN
    , .sign_ext(sign_ext)
`endif
  );

  mem_op_controller #(.ADDR_W(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .MFA(mfa0), .RW(RW), .size(size), .addr(addr),
    .wdata(wdata), .MOC(MOC0), .rdata(rdata0), .err(err0), .busy(busy0),
    .ram_en(ram_en0), .ram_we(ram_we0), .ram_be(ram_be0), .ram_addr(ram_addr0),
    .ram_wdata(ram_wdata0), .ram_rdata(ram_rdata)
`ifdef MEMCTRL_SIGN_EXT_EN
    , .sign_ext(sign_ext)
`endif
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  int          en_cyc, moc_edge;
  logic        we_all, we_any;
  logic [3:0]  be_seen;
  logic [31:0] wd_seen;
  logic [7:0]  addr_seen;

  // Hold MFA until MOC; scramble request inputs right after capture.
  task automatic run(input logic rw, input logic [1:0] sz, input logic [7:0] a,
                     input logic [31:0] wd, input logic sx);
    RW = rw; size = sz; addr = a; wdata = wd; sign_ext = sx; MFA = 1'b1;
    en_cyc = 0; moc_edge = 0; we_all = 1'b1; we_any = 1'b0;
    be_seen = '0; wd_seen = '0; addr_seen = '0;
    for (int i = 1; i <= 30 && moc_edge == 0; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin RW = ~rw; addr = ~a; wdata = ~wd; sign_ext = ~sx; end
      if (ram_en) begin
        en_cyc++;
        we_all &= ram_we; we_any |= ram_we;
        be_seen = ram_be; wd_seen = ram_wdata; addr_seen = ram_addr;
      end
      if (MOC) moc_edge = i;
    end
    chk("moc_seen", {31'd0, moc_edge != 0}, 32'd1);
  endtask

  task automatic release_mfa(input string tag);
    MFA = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_moc_low"}, {31'd0, MOC}, 32'd0);
    chk({tag, "_err_low"}, {31'd0, err}, 32'd0);
    chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
  endtask

  int          n_en0, n_moc0;
  logic [31:0] exp_half;

  initial begin
    MFA = 0; mfa0 = 0; RW = 1; size = 2'b10; addr = '0; wdata = '0;
    sign_ext = 0; ram_rdata = 32'hDEADBEEF;
    #1;
    chk("rst_moc",   {31'd0, MOC}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_en",    {31'd0, ram_en}, 32'd0);
    chk("rst_be",    {28'd0, ram_be}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_wdata", ram_wdata, 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;

    // word read
    run(1'b1, 2'b10, 8'h10, 32'h0, 1'b0);
    chk("wr_en_cycles", en_cyc, 32'd3);
    chk("wr_moc_edge",  moc_edge, 32'd4);
    chk("wr_we",        {31'd0, we_any}, 32'd0);
    chk("wr_be",        {28'd0, be_seen}, 32'hF);
    chk("wr_addr",      {24'd0, addr_seen}, 32'h10);
    chk("wr_rdata",     rdata, 32'hDEADBEEF);
    chk("wr_err",       {31'd0, err}, 32'd0);
    release_mfa("wr");

    // byte write, top lane
    run(1'b0, 2'b00, 8'h13, 32'h000000A5, 1'b0);
    chk("sb_en_cycles", en_cyc, 32'd3);
    chk("sb_we_all",    {31'd0, we_all}, 32'd1);
    chk("sb_be",        {28'd0, be_seen}, 32'h8);
    chk("sb_wdata",     wd_seen, 32'hA5A5A5A5);
    chk("sb_err",       {31'd0, err}, 32'd0);
    release_mfa("sb");

    // halfword read, upper half
    ram_rdata = 32'h80017F00;
    run(1'b1, 2'b01, 8'h02, 32'h0, 1'b0);
    chk("lh_be",    {28'd0, be_seen}, 32'hC);
    chk("lh_rdata", rdata, 32'h00008001);
    release_mfa("lh");

`ifdef MEMCTRL_SIGN_EXT_EN
    exp_half = 32'hFFFF8001;
`else
    exp_half = 32'h00008001;
`endif
    run(1'b1, 2'b01, 8'h02, 32'h0, 1'b1);
    chk("lh_sx_rdata", rdata, exp_half);
    release_mfa("lhsx");

    // byte read, lane 1 (0x7F stays positive either way)
    run(1'b1, 2'b00, 8'h01, 32'h0, 1'b1);
    chk("lb_be",    {28'd0, be_seen}, 32'h2);
    chk("lb_rdata", rdata, 32'h0000007F);
    release_mfa("lb");

    // reserved size as word, halfword write lanes
    run(1'b1, 2'b11, 8'h0C, 32'h0, 1'b0);
    chk("rsv_be",    {28'd0, be_seen}, 32'hF);
    chk("rsv_rdata", rdata, 32'h80017F00);
    release_mfa("rsv");
    run(1'b0, 2'b01, 8'h06, 32'h0000BEEF, 1'b0);
    chk("sh_be",    {28'd0, be_seen}, 32'hC);
    chk("sh_wdata", wd_seen, 32'hBEEFBEEF);
    release_mfa("sh");

    // misaligned word write and halfword read
    run(1'b0, 2'b10, 8'h05, 32'h12345678, 1'b0);
    chk("mis_w_en",   en_cyc, 32'd0);
    chk("mis_w_edge", moc_edge, 32'd1);
    chk("mis_w_err",  {31'd0, err}, 32'd1);
    release_mfa("misw");
    run(1'b1, 2'b01, 8'h03, 32'h0, 1'b0);
    chk("mis_h_en",  en_cyc, 32'd0);
    chk("mis_h_err", {31'd0, err}, 32'd1);
    release_mfa("mish");

    // asynchronous reset in the 2nd ACCESS cycle
    RW = 1; size = 2'b10; addr = 8'h20; MFA = 1;
    @(posedge clk); #1;
    chk("ar_en1", {31'd0, ram_en}, 32'd1);
    @(posedge clk); #1;
    chk("ar_busy2", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_en_drop",   {31'd0, ram_en}, 32'd0);
    chk("ar_busy_drop", {31'd0, busy}, 32'd0);
    chk("ar_moc_drop",  {31'd0, MOC}, 32'd0);
    #1 reset = 1'b1;
    ram_rdata = 32'hCAFEF00D;
    run(1'b1, 2'b10, 8'h20, 32'h0, 1'b0);
    chk("ar_re_en",    en_cyc, 32'd3);
    chk("ar_re_edge",  moc_edge, 32'd4);
    chk("ar_re_rdata", rdata, 32'hCAFEF00D);
    release_mfa("ar");

    // WAIT_STATES=0 instance, MFA held for 5 edges
    RW = 1; size = 2'b10; addr = 8'h00; ram_rdata = 32'h12345678; mfa0 = 1;
    n_en0 = 0; n_moc0 = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (ram_en0) n_en0++;
      if (MOC0) n_moc0++;
    end
    chk("w0_en_cycles", n_en0, 32'd1);
    chk("w0_moc_cycles", n_moc0, 32'd4);
    chk("w0_rdata", rdata0, 32'h12345678);
    mfa0 = 0;
    @(posedge clk); #1;
    chk("w0_moc_low", {31'd0, MOC0}, 32'd0);
    chk("w0_en_low",  {31'd0, ram_en0}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
